// File: rtl/fixed_point_divider_if.sv
// Operand/result bundle for the unsigned Q6.4 divider.
// The master side issues start with operands; the slave side reports the result and flags.
interface fixed_point_divider_if #(
  parameter int W = 10
);
  logic         start;
  logic [W-1:0] a_bus;
  logic [W-1:0] b_bus;
  logic         dvz;
  logic         ovf;
  logic         busy;
  logic         valid;
  logic [W-1:0] out_bus;

  modport master (
    output start, a_bus, b_bus,
    input  dvz, ovf, busy, valid, out_bus
  );

  modport slave (
    input  start, a_bus, b_bus,
    output dvz, ovf, busy, valid, out_bus
  );
endinterface

// File: rtl/fixed_point_divider.sv
// Restoring shift-subtract unsigned fixed-point divider, one quotient bit per clock.
// Result valid W+FRAC+1 cycles after an accepted start (1 cycle on divide-by-zero); start ignored unless idle.
module fixed_point_divider #(
  parameter int W    = 10,
  parameter int FRAC = 4
) (
  input  logic                  clk,
  input  logic                  sclr,
  fixed_point_divider_if.slave  bus
);

  localparam int QW = W + FRAC;
  localparam int CW = $clog2(QW);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  state_t          state_nxt;
  logic            accept;

  logic [QW-1:0]   dvd;
  logic [QW-1:0]   quo;
  logic [W:0]      rem;
  logic [W-1:0]    b_reg;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    out_r;
  logic            dvz_r;
  logic            ovf_r;

  logic [W:0]      rem_sh;
  logic [W:0]      rem_nxt;
  logic            ge;
  logic [QW-1:0]   quo_nxt;
  logic            last;

  // One restoring step: the partial remainder stays below b, so W+1 bits hold the shifted value.
  always_comb begin
    rem_sh  = (W+1)'({rem, dvd[QW-1]});
    ge      = (rem_sh >= {1'b0, b_reg});
    rem_nxt = ge ? (rem_sh - {1'b0, b_reg}) : rem_sh;
    quo_nxt = QW'({quo, ge});
    last    = (cnt == CW'(QW - 1));
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = (bus.b_bus == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      dvd   <= '0;
      quo   <= '0;
      rem   <= '0;
      b_reg <= '0;
      cnt   <= '0;
      out_r <= '0;
      dvz_r <= 1'b0;
      ovf_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            b_reg <= bus.b_bus;
            dvd   <= {bus.a_bus, {FRAC{1'b0}}};
            rem   <= '0;
            quo   <= '0;
            cnt   <= '0;
            ovf_r <= 1'b0;
            dvz_r <= (bus.b_bus == '0);
            out_r <= (bus.b_bus == '0) ? '1 : '0;
          end
        end
        RUN: begin
          dvd <= {dvd[QW-2:0], 1'b0};
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + 1'b1;
          // Quotient bits above W mean the result does not fit: saturate.
          if (last) begin
            if (quo_nxt[QW-1:W] != '0) begin
              ovf_r <= 1'b1;
              out_r <= '1;
            end else begin
              out_r <= quo_nxt[W-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = (state == RUN);
  assign bus.valid   = (state == DONE);
  assign bus.out_bus = out_r;
  assign bus.dvz     = dvz_r;
  assign bus.ovf     = ovf_r;

endmodule

// File: tb/tb_fixed_point_divider.sv
// Scoreboard bench for fixed_point_divider: expected results queued at start, checked on valid.
module tb_fixed_point_divider;

  localparam int W    = 10;
  localparam int FRAC = 4;

  typedef struct {
    logic [W-1:0] out;
    logic         dvz;
    logic         ovf;
  } exp_t;

  logic clk = 1'b0;
  logic sclr;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  fixed_point_divider_if #(.W(W)) dif ();

  fixed_point_divider #(.W(W), .FRAC(FRAC)) dut (
    .clk  (clk),
    .sclr (sclr),
    .bus  (dif)
  );

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   q;
    e.dvz = 1'b0;
    e.ovf = 1'b0;
    if (b == '0) begin
      e.dvz = 1'b1;
      e.out = '1;
    end else begin
      q = (int'(a) * (1 << FRAC)) / int'(b);
      if (q > (1 << W) - 1) begin
        e.ovf = 1'b1;
        e.out = '1;
      end else begin
        e.out = W'(q);
      end
    end
    return e;
  endfunction

  // Entered at the falling edge of the first cycle after acceptance; leaves one cycle after valid.
  task automatic wait_result(input string name, input int exp_lat, input int exp_busy);
    int   n = 0;
    int   busy_cnt = 0;
    bit   got = 0;
    exp_t e;
    while (!got && n < 40) begin
      n++;
      if (dif.busy) busy_cnt++;
      if (dif.valid) got = 1;
      else @(negedge clk);
    end
    e = (sb.size() > 0) ? sb.pop_front() : '{default: '0};
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL %s_timeout: no valid within %0d cycles", name, n);
      return;
    end
    if (n !== exp_lat) begin
      miscompares++;
      $display("FAIL %s_latency: got %0d want %0d", name, n, exp_lat);
    end
    vectors++;
    if (busy_cnt !== exp_busy) begin
      miscompares++;
      $display("FAIL %s_busy_cycles: got %0d want %0d", name, busy_cnt, exp_busy);
    end
    vectors++;
    if (dif.out_bus !== e.out) begin
      miscompares++;
      $display("FAIL %s_out_bus: got %h want %h", name, dif.out_bus, e.out);
    end
    vectors++;
    if ({dif.dvz, dif.ovf} !== {e.dvz, e.ovf}) begin
      miscompares++;
      $display("FAIL %s_flags: got dvz=%b ovf=%b want dvz=%b ovf=%b", name, dif.dvz, dif.ovf, e.dvz, e.ovf);
    end
    @(negedge clk);
    vectors++;
    if (dif.valid !== 1'b0 || dif.out_bus !== e.out || dif.dvz !== e.dvz || dif.ovf !== e.ovf) begin
      miscompares++;
      $display("FAIL %s_hold: got valid=%b out=%h dvz=%b ovf=%b want valid=0 out=%h dvz=%b ovf=%b",
               name, dif.valid, dif.out_bus, dif.dvz, dif.ovf, e.out, e.dvz, e.ovf);
    end
  endtask

  task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    dif.a_bus = a;
    dif.b_bus = b;
    dif.start = 1'b1;
    sb.push_back(model(a, b));
    @(negedge clk);
    dif.start = 1'b0;
    wait_result(name, (b == '0) ? 1 : W + FRAC + 1, (b == '0) ? 0 : W + FRAC);
  endtask

  task automatic check_quiet(input string name, input int cycles);
    int valids = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (dif.valid) valids++;
    end
    vectors++;
    if (valids !== 0) begin
      miscompares++;
      $display("FAIL %s_extra_valid: got %0d pulses want 0", name, valids);
    end
  endtask

  task automatic test_reset();
    sclr      = 1'b1;
    dif.start = 1'b1;
    dif.a_bus = 10'h0B3;
    dif.b_bus = 10'h009;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({dif.busy, dif.valid, dif.dvz, dif.ovf} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags: got busy=%b valid=%b dvz=%b ovf=%b want all 0",
               dif.busy, dif.valid, dif.dvz, dif.ovf);
    end
    vectors++;
    if (dif.out_bus !== '0) begin
      miscompares++;
      $display("FAIL reset_out_bus: got %h want 000", dif.out_bus);
    end
    dif.start = 1'b0;
    sclr      = 1'b0;
  endtask

  task automatic test_basic();
    do_op("basic", 10'h0B3, 10'h009);
    do_op("unity", 10'h010, 10'h010);
    do_op("zero_dividend", 10'h000, 10'h005);
  endtask

  task automatic test_overflow();
    do_op("overflow", 10'h3FF, 10'h001);
    do_op("edge_fit", 10'h3FF, 10'h010);
  endtask

  task automatic test_div_zero();
    do_op("div_zero", 10'h0B3, 10'h000);
  endtask

  task automatic test_ignore_start();
    @(negedge clk);
    dif.a_bus = 10'h0B3;
    dif.b_bus = 10'h009;
    dif.start = 1'b1;
    sb.push_back(model(10'h0B3, 10'h009));
    @(negedge clk);
    dif.start = 1'b0;
    fork
      wait_result("ignore_start", W + FRAC + 1, W + FRAC);
      begin
        repeat (5) @(posedge clk);
        #1;
        dif.a_bus = 10'h200;
        dif.b_bus = 10'h003;
        dif.start = 1'b1;
        @(posedge clk);
        #1;
        dif.start = 1'b0;
      end
    join
    check_quiet("ignore_start", 20);
  endtask

  task automatic test_sclr_abort();
    @(negedge clk);
    dif.a_bus = 10'h0B3;
    dif.b_bus = 10'h009;
    dif.start = 1'b1;
    @(negedge clk);
    dif.start = 1'b0;
    repeat (6) @(negedge clk);
    sclr = 1'b1;
    @(negedge clk);
    sclr = 1'b0;
    vectors++;
    if ({dif.busy, dif.valid, dif.dvz, dif.ovf} !== 4'b0000 || dif.out_bus !== '0) begin
      miscompares++;
      $display("FAIL sclr_abort_outputs: got busy=%b valid=%b dvz=%b ovf=%b out=%h want all 0",
               dif.busy, dif.valid, dif.dvz, dif.ovf, dif.out_bus);
    end
    check_quiet("sclr_abort", 20);
    do_op("after_abort", 10'h100, 10'h030);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    dif.a_bus = 10'h0B3;
    dif.b_bus = 10'h009;
    dif.start = 1'b1;
    sb.push_back(model(10'h0B3, 10'h009));
    @(negedge clk);
    dif.a_bus = 10'h010;
    dif.b_bus = 10'h010;
    sb.push_back(model(10'h010, 10'h010));
    wait_result("b2b_first", W + FRAC + 1, W + FRAC);
    @(negedge clk);
    dif.start = 1'b0;
    wait_result("b2b_second", W + FRAC + 1, W + FRAC);
  endtask

  task automatic test_random();
    logic [W-1:0] a;
    logic [W-1:0] b;
    for (int i = 0; i < 6; i++) begin
      a = W'($urandom_range(0, 1023));
      b = (i % 2 == 0) ? W'($urandom_range(1, 1023)) : W'($urandom_range(0, 31));
      do_op("random", a, b);
    end
  endtask

  initial begin
    dif.start = 1'b0;
    dif.a_bus = '0;
    dif.b_bus = '0;
    sclr      = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_div_zero();
    test_ignore_start();
    test_sclr_abort();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
